seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
Sequences the Basys 3 four-digit 7-segment display. It time-multiplexes the digits with a dead-time blanking interval between them to prevent ghosting. It accepts new 16-bit display values through a valid/ready handshake and commits them only at frame boundaries, so no partially updated frame is ever shown. It sits between the top level's value/button logic and the seg/an pins.

Parameters:
DIGIT_CYCLES, 100000, clk cycles each digit is driven (1 ms at 100 MHz); must be >= 2.
BLANK_CYCLES, 1000, clk cycles all anodes are off between digits; must be >= 1.

Ports:
clk  in  1  100 MHz system clock
rst  in  1  reset: asynchronous assert, active-low (0 = reset)
wr_valid  in  1  requester presents a new display value
wr_ready  out  1  controller can accept a value (pending slot empty)
wr_data  in  16  four hex nibbles; [3:0] = digit 0 (rightmost)
wr_dp  in  4  decimal-point enables per digit, bit i = digit i
lz_suppress  in  1  blank leading-zero digits 3..1
blank_all  in  1  force the display dark while high
seg  out  7  segments a-g, active-low
dp  out  1  decimal point, active-low
an  out  4  digit anodes, active-low; an[i] drives digit i

Behaviour:
- Reset values: an=4'hF, seg=7'h7F, dp=1, wr_ready=1. Internal: state=BLANK, cycle counter=0, digit idx=0, shown value=0, shown dp=0, pending slot empty.
- FSM states:
  - BLANK: an=4'hF for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: drives digit idx for DIGIT_CYCLES cycles, then go to BLANK with idx <= idx+1 mod 4 (3 wraps to 0).
- The counter resets to 0 on every state transition.
- One frame is 4*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
- seg, dp and an are registered. They reflect the state/idx of the previous cycle (1-cycle latency).
- Write handshake:
  - A transfer occurs when wr_valid && wr_ready on a clk edge. wr_data and wr_dp are captured into the pending slot, and wr_ready goes 0 the next cycle.
  - wr_valid while wr_ready=0 is ignored. The requester holds it until ready.
- Commit:
  - On the BLANK->DRIVE transition with idx==0, a full pending slot is copied into the shown registers and the slot is emptied. wr_ready returns to 1 the following cycle.
  - No commit occurs at any other transition, so digits within one frame always come from the same value.
  - A write accepted in the same cycle as a commit edge is not possible, because ready is 0 whenever the slot is full.
- Digit decode:
  - seg = hex-to-7seg of nibble idx of the shown value, covering 0-F.
  - dp = ~shown_dp[idx].
- Leading-zero suppression (lz_suppress=1): digit i in {3,2,1} is blanked (seg=7'h7F, dp still honoured) if nibbles i..3 are all zero. Digit 0 is never suppressed.
- blank_all=1 forces an=4'hF in both states. The FSM, counter, idx and handshake continue unaffected, so releasing blank_all resumes mid-frame without a glitch.
- lz_suppress and blank_all are sampled combinationally each cycle. They are not latched per frame.
- Reset mid-operation (rst low at any time):
  - All state returns to reset values immediately (asynchronous), and the pending value is discarded.
  - After rst deasserts, the first DRIVE of digit 0 begins BLANK_CYCLES cycles later.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_BLANK = 7'h7F
  - AN_OFF = 4'hF
  - NUM_DIGITS = 4
  - the state enum {BLANK, DRIVE}
  - the 16-entry hex-to-segment constant table
- One sub-module, hex_to_seg: purely combinational, 4-bit nibble in, 7-bit active-low segments out, using the package table.
- The FSM, counter, handshake and suppression logic live in seg_scan_controller.

Test Plan:
Bench parameters: DIGIT_CYCLES=8, BLANK_CYCLES=2.
1. Reset then free-run, no writes -> an sequence 1111(x2), 1110(x8), 1111(x2), 1101(x8), 1111(x2), 1011(x8), 1111(x2), 0111(x8), repeating; seg=7'h40 ("0") whenever an != 1111.
2. Write 16'h12AF, wr_dp=4'b0100, mid-frame -> wr_ready=0 next cycle; old value completes its frame; next frame shows digit0 seg "F"=7'h0E, digit1 "A"=7'h08, digit2 "2"=7'h24 with dp=0, digit3 "1"=7'h79; wr_ready=1 one cycle after commit.
3. Hold wr_valid with 16'h0001 then 16'h0002 back-to-back -> second value accepted only after the first commits; frames show 0001 fully, then 0002 fully, never mixed.
4. lz_suppress=1, value 16'h0050 -> digits 3 and 2 seg=7'h7F, digit1 "5"=7'h12, digit0 "0"=7'h40. Value 16'h0000 -> only digit 0 lit.
5. blank_all pulsed for 5 cycles during DRIVE of digit 2 -> an=1111 for those cycles, then 1011 resumes for the remaining count; frame period unchanged.
6. rst low for 1 cycle mid-DRIVE of digit 3 with a pending write -> an=1111 and seg=7'h7F immediately, wr_ready=1, pending discarded; display restarts at digit 0 showing 0000.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, state type and hex-to-segment table for the 7-segment scan controller.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [3:0] AN_OFF     = 4'hF;
   localparam int         NUM_DIGITS = 4;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } state_t;

   // Active-low segments, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg_scan_controller_if.sv
// Write handshake between the value/button logic and the scan controller.
interface seg_scan_controller_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_data;
   logic [3:0]  wr_dp;

   modport master (output wr_valid, output wr_data, output wr_dp, input wr_ready);
   modport slave  (input wr_valid, input wr_data, input wr_dp, output wr_ready);
endinterface

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low 7-segment decode.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup covering 0-F
   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit 7-segment scan controller with dead-time blanking between digits
// and frame-aligned commit of new display values.
//
// state | meaning
// BLANK | all anodes off for BLANK_CYCLES; commit point when idx wraps to 0
// DRIVE | digit idx driven for DIGIT_CYCLES, then idx advances
module seg_scan_controller
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                        clk,
   input  logic                        rst,
   seg_scan_controller_if.slave        wr,
   input  logic                        lz_suppress,
   input  logic                        blank_all,
   output logic [6:0]                  seg,
   output logic                        dp,
   output logic [3:0]                  an
);

   localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int IW      = $clog2(NUM_DIGITS);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   idx;
   logic            cnt_tc;
   logic            accept;
   logic            commit;
   logic [15:0]     shown_val;
   logic [3:0]      shown_dp;
   logic [15:0]     pend_val;
   logic [3:0]      pend_dp;
   logic            pend_full;
   logic [3:0]      nib;
   logic [6:0]      seg_dec;
   logic            lz_blank;

   assign cnt_tc = (state_q == BLANK) ? (cnt == CW'(BLANK_CYCLES - 1))
                                      : (cnt == CW'(DIGIT_CYCLES - 1));
   assign accept      = wr.wr_valid && !pend_full;
   assign commit      = (state_q == BLANK) && cnt_tc && (idx == '0) && pend_full;
   assign wr.wr_ready = !pend_full;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= BLANK;
      else      state_q <= state_d;
   end

   // Next state: each phase ends on its terminal count
   always_comb begin
      state_d = state_q;
      case (state_q)
         BLANK:   if (cnt_tc) state_d = DRIVE;
         DRIVE:   if (cnt_tc) state_d = BLANK;
         default: state_d = BLANK;
      endcase
   end

   // Phase counter restarts on every transition; digit index advances after each DRIVE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= cnt_tc ? '0 : cnt + CW'(1);
         if (state_q == DRIVE && cnt_tc) idx <= idx + IW'(1);
      end
   end

   // Pending slot fills on a transfer and drains into the shown value at the frame start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_val  <= '0;
         pend_dp   <= '0;
         pend_full <= 1'b0;
         shown_val <= '0;
         shown_dp  <= '0;
      end else if (accept) begin
         pend_val  <= wr.wr_data;
         pend_dp   <= wr.wr_dp;
         pend_full <= 1'b1;
      end else if (commit) begin
         shown_val <= pend_val;
         shown_dp  <= pend_dp;
         pend_full <= 1'b0;
      end
   end

   assign nib = shown_val[{idx, 2'b00} +: 4];

   hex_to_seg u_hex (
      .nibble (nib),
      .seg    (seg_dec)
   );

   // Digit i is a leading zero when it and every higher nibble are zero
   always_comb begin
      lz_blank = 1'b0;
      case (idx)
         2'd1:    lz_blank = (shown_val[15:4]  == '0);
         2'd2:    lz_blank = (shown_val[15:8]  == '0);
         2'd3:    lz_blank = (shown_val[15:12] == '0);
         default: lz_blank = 1'b0;
      endcase
   end

   // Registered pin drive; blank_all only gates the outputs, never the sequencing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else if (state_q == DRIVE && !blank_all) begin
         an  <= ~(4'b0001 << idx);
         seg <= (lz_suppress && lz_blank) ? SEG_BLANK : seg_dec;
         dp  <= ~shown_dp[idx];
      end else begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller: frame-arithmetic reference model,
// per-cycle compare, directed scenarios with literal expectations, random phase.
module tb_seg_scan_controller;

   localparam int D  = 8;
   localparam int B  = 2;
   localparam int FR = 4 * (D + B);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lz_suppress = 1'b0;
   logic       blank_all = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   seg_scan_controller_if wr_if ();

   seg_scan_controller #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr          (wr_if),
      .lz_suppress (lz_suppress),
      .blank_all   (blank_all),
      .seg         (seg),
      .dp          (dp),
      .an          (an)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   logic [6:0] hex_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: position in the frame is pure arithmetic on cycles since reset
   int         k;
   logic [15:0] m_shown, m_pend;
   logic [3:0]  m_shown_dp, m_pend_dp;
   bit          m_full;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;

   always @(posedge clk or negedge rst) begin : model
      int p, slot;
      bit drv, acc, com;
      if (!rst) begin
         k = 0; m_shown = '0; m_shown_dp = '0; m_pend = '0; m_pend_dp = '0; m_full = 0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         p    = k % FR;
         slot = p / (D + B);
         drv  = (p % (D + B)) >= B;
         if (drv && !blank_all) begin
            e_an = ~(4'b0001 << slot);
            if (lz_suppress && slot > 0 && (m_shown >> (4 * slot)) == 16'h0)
               e_seg = 7'h7F;
            else
               e_seg = hex_tab[(m_shown >> (4 * slot)) & 16'hF];
            e_dp = ~m_shown_dp[slot];
         end else begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         end
         acc = wr_if.wr_valid && !m_full;
         com = (p == B - 1) && m_full;
         if (com) begin
            m_shown = m_pend; m_shown_dp = m_pend_dp; m_full = 0;
         end
         if (acc) begin
            m_pend = wr_if.wr_data; m_pend_dp = wr_if.wr_dp; m_full = 1;
         end
         k++;
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         check("an", an, e_an);
         if (e_an != 4'hF) begin
            check("seg", seg, e_seg);
            check("dp", dp, e_dp);
         end
         check("wr_ready", wr_if.wr_ready, !m_full);
      end
   end

   task automatic wait_an(input logic [3:0] tgt);
      int n = 0;
      while (an == tgt && n < 300) begin @(negedge clk); n++; end
      while (an != tgt && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) check("wait_an_timeout", an, tgt);
   endtask

   task automatic do_write(input logic [15:0] v, input logic [3:0] d);
      int n = 0;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = v;
      wr_if.wr_dp    = d;
      while (!wr_if.wr_ready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) check("write_timeout", wr_if.wr_ready, 1);
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] seq [FR];
      logic       rdy_prev;
      int         cnt;

      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = '0;
      wr_if.wr_dp    = '0;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_ready", wr_if.wr_ready, 1'b1);
      cmp_en = 1'b1;
      #2 rst = 1'b1;

      // 1: free-running scan pattern
      for (int s = 0; s < 4; s++)
         for (int j = 0; j < D + B; j++)
            seq[s * (D + B) + j] = (j < B) ? 4'hF : ~(4'b0001 << s);
      for (int j = 0; j < FR; j++) begin
         @(negedge clk);
         check("t1_an", an, seq[j]);
         if (an != 4'hF) check("t1_seg", seg, 7'h40);
      end

      // 2: write mid-frame, commit on next frame
      wait_an(4'hD);
      do_write(16'h12AF, 4'b0100);
      check("t2_ready_low", wr_if.wr_ready, 1'b0);
      wait_an(4'hE);
      check("t2_d0", seg, 7'h0E);
      check("t2_ready_back", wr_if.wr_ready, 1'b1);
      wait_an(4'hD);
      check("t2_d1", seg, 7'h08);
      wait_an(4'hB);
      check("t2_d2", seg, 7'h24);
      check("t2_d2_dp", dp, 1'b0);
      wait_an(4'h7);
      check("t2_d3", seg, 7'h79);
      check("t2_d3_dp", dp, 1'b1);

      // 3: back-to-back writes
      do_write(16'h0001, 4'h0);
      do_write(16'h0002, 4'h0);
      check("t3_an_first", an, 4'hE);
      check("t3_seg_first", seg, 7'h79);
      wait_an(4'h7);
      wait_an(4'hE);
      check("t3_seg_second", seg, 7'h24);

      // 4: leading-zero suppression
      lz_suppress = 1'b1;
      do_write(16'h0050, 4'h0);
      wait_an(4'h7);
      wait_an(4'hE);
      check("t4_d0", seg, 7'h40);
      wait_an(4'hD);
      check("t4_d1", seg, 7'h12);
      wait_an(4'hB);
      check("t4_d2", seg, 7'h7F);
      wait_an(4'h7);
      check("t4_d3", seg, 7'h7F);
      do_write(16'h0000, 4'h0);
      wait_an(4'h7);
      wait_an(4'hE);
      check("t4z_d0", seg, 7'h40);
      wait_an(4'hD);
      check("t4z_d1", seg, 7'h7F);
      wait_an(4'hB);
      check("t4z_d2", seg, 7'h7F);
      wait_an(4'h7);
      check("t4z_d3", seg, 7'h7F);
      lz_suppress = 1'b0;

      // 5: blank_all pulse during digit 2
      wait_an(4'hB);
      @(negedge clk);
      blank_all = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check("t5_blank", an, 4'hF);
      end
      blank_all = 1'b0;
      @(negedge clk);
      check("t5_resume", an, 4'hB);
      cnt = 0;
      while (an != 4'h7 && cnt < 50) begin @(negedge clk); cnt++; end
      check("t5_period", cnt, 3);

      // 6: reset mid-DRIVE of digit 3 with a pending write
      wait_an(4'hB);
      do_write(16'hBEEF, 4'hF);
      wait_an(4'h7);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("t6_an", an, 4'hF);
      check("t6_seg", seg, 7'h7F);
      check("t6_ready", wr_if.wr_ready, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      wait_an(4'hE);
      check("t6_d0", seg, 7'h40);
      wait_an(4'hD);
      check("t6_d1", seg, 7'h40);
      wait_an(4'hB);
      check("t6_d2", seg, 7'h40);
      wait_an(4'h7);
      check("t6_d3", seg, 7'h40);
      check("t6_d3_dp", dp, 1'b1);

      // Random phase against the model
      rdy_prev = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (i == 1500) begin
            wr_if.wr_valid = 1'b0;
            #2 rst = 1'b0;
            @(negedge clk);
            #2 rst = 1'b1;
            @(negedge clk);
            rdy_prev = 1'b0;
         end
         if (wr_if.wr_valid && rdy_prev) wr_if.wr_valid = 1'b0;
         if (!wr_if.wr_valid && $urandom_range(0, 29) == 0) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = 16'($urandom);
            wr_if.wr_dp    = 4'($urandom);
         end
         if ($urandom_range(0, 99) == 0) lz_suppress = ~lz_suppress;
         blank_all = ($urandom_range(0, 19) == 0);
         rdy_prev  = wr_if.wr_ready;
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
